// File: rtl/audio_mux_mc.sv
// audio_mux_mc: multi-channel HPS sample mux with voice-engine trigger generation.
// Channels are read over a word register port; the trigger follows synchronised lrck
// in I2S mode (buffersize==0) or issues counted run_trig pulses to prefill a buffer.
// Optional build macro: AUDIO_MUX_OVERRUN_DET_EN adds a sticky overrun flag (status[24]).
module audio_mux_mc #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned AUD_BIT_DEPTH = 24,
  parameter int unsigned FIFO_WIDTH    = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [3:0]                      address,
  input  logic                            read,
  input  logic                            write,
  input  logic [31:0]                     datain,
  input  logic [NUM_CH*AUD_BIT_DEPTH-1:0] sound_in,
  input  logic                            xxxx_top,
  input  logic                            lrck,
  input  logic                            run,
  output logic [31:0]                     dataout,
  output logic [NUM_CH-1:0]               ch_read,
  output logic                            trig,
  output logic                            i2s_enable,
  output logic                            sample_ready,
  output logic [1:0]                      sr_code
);

  localparam int unsigned CW = FIFO_WIDTH + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   counter_q;
  logic [CW-1:0]   bsize_q;
  logic [31:0]     samplerate_q;
  logic            ctrl_q;
  logic            jack_prev_q;
  logic            run_trig_q;
  logic [1:0]      sr_code_q;
  logic [31:0]     dataout_q;
  (* ASYNC_REG = "TRUE" *) logic lrck_meta_q;
  (* ASYNC_REG = "TRUE" *) logic lrck_sync_q;

  logic            wr_ctrl, wr_bsize, wr_sr, wr_status;
  logic            jack_cycle_end;
  logic            fill_fire;
  logic            overrun;
  logic [31:0]     status;
  logic [31:0]     rd_data;

  assign wr_ctrl   = write && (address == 4'd8);
  assign wr_bsize  = write && (address == 4'd9);
  assign wr_sr     = write && (address == 4'd10);
  assign wr_status = write && (address == 4'd11);

  // End of a jack read cycle is the 1->0 edge of the registered jack_read_act bit.
  assign jack_cycle_end = jack_prev_q && !ctrl_q;
  assign fill_fire      = xxxx_top && !run && (counter_q < bsize_q);

  function automatic logic [1:0] sr_decode(input logic [31:0] rate);
    case (rate)
      32'd44100: sr_decode = 2'd1;
      32'd48000: sr_decode = 2'd2;
      32'd96000: sr_decode = 2'd3;
      default:   sr_decode = 2'd0;
    endcase
  endfunction

  // Control registers; sr_code decodes the written value so it lands one clock after the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q       <= 1'b0;
      jack_prev_q  <= 1'b0;
      bsize_q      <= '0;
      samplerate_q <= '0;
      sr_code_q    <= 2'd0;
    end else begin
      jack_prev_q <= ctrl_q;
      if (wr_ctrl) ctrl_q <= datain[0];
      if (wr_bsize) bsize_q <= datain[CW-1:0];
      if (wr_sr) begin
        samplerate_q <= datain;
        sr_code_q    <= sr_decode(datain);
      end
    end
  end

  // Two-flop synchroniser for the asynchronous word clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lrck_meta_q <= 1'b0;
      lrck_sync_q <= 1'b0;
    end else begin
      lrck_meta_q <= lrck;
      lrck_sync_q <= lrck_meta_q;
    end
  end

  // Fill FSM with registered run_trig; a restart in FILL clears the counter but keeps the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      counter_q  <= '0;
      run_trig_q <= 1'b0;
    end else begin
      run_trig_q <= 1'b0;
      if (wr_bsize && (datain[CW-1:0] == '0)) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if ((bsize_q != '0) && jack_cycle_end) begin
              state_q   <= StFill;
              counter_q <= '0;
            end
          end
          StFill: begin
            if (fill_fire) run_trig_q <= 1'b1;
            if (jack_cycle_end) begin
              counter_q <= '0;
            end else if (counter_q >= bsize_q) begin
              // Also covers buffersize shrunk below the current count.
              state_q <= StDone;
            end else if (fill_fire) begin
              counter_q <= counter_q + CW'(1);
            end
          end
          StDone: begin
            if (jack_cycle_end) begin
              state_q   <= StFill;
              counter_q <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef AUDIO_MUX_OVERRUN_DET_EN
  logic overrun_q;

  // Sticky overrun: a jack cycle ended before the prefill completed; set beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (jack_cycle_end && (state_q == StFill)) begin
      overrun_q <= 1'b1;
    end else if (wr_status) begin
      overrun_q <= 1'b0;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  // Status word assembly.
  always_comb begin
    status         = '0;
    status[CW-1:0] = counter_q;
    status[17:16]  = state_q;
    status[24]     = overrun;
  end

  // Read mux: channels left-justified, unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    case (address)
      4'd8:    rd_data = {31'd0, ctrl_q};
      4'd9:    rd_data = 32'(bsize_q);
      4'd10:   rd_data = samplerate_q;
      4'd11:   rd_data = status;
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (address == 4'(n)) begin
            rd_data = 32'(sound_in[n*AUD_BIT_DEPTH +: AUD_BIT_DEPTH]) << (32 - AUD_BIT_DEPTH);
          end
        end
      end
    endcase
  end

  // Per-channel read strobes, decoded straight from the bus.
  always_comb begin
    ch_read = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ch_read[n] = read && (address == 4'(n));
    end
  end

  // Registered read data, updated only on a read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataout_q <= '0;
    end else if (read) begin
      dataout_q <= rd_data;
    end
  end

  assign dataout      = dataout_q;
  assign i2s_enable   = (bsize_q == '0);
  assign trig         = i2s_enable ? lrck_sync_q : run_trig_q;
  assign sample_ready = 1'b1;
  assign sr_code      = sr_code_q;

endmodule
